alu_cdb_issue_unit: RTL and testbench



---
 rtl/alu_cdb_issue_unit_pkg.sv | 55 +++++
 rtl/alu_cdb_issue_unit_alu_exec.sv | 60 ++++++
 rtl/alu_cdb_issue_unit.sv | 120 ++++++++++++
 tb/tb_alu_cdb_issue_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cdb_issue_unit_pkg.sv
// Shared types for the Tomasulo ALU path: the issued operation word, the
// CDB payload and the funct3 encodings used by the ALU.
package tomasula_types;

    typedef logic [31:0] cdb_data;

    typedef enum logic [3:0] {
        ARITH,
        BRANCH,
        AUIPC,
        LUI,
        JAL,
        JALR,
        LD,
        SB,
        SH,
        SW,
        CSR
    } alu_op_t;

    typedef struct packed {
        alu_op_t     op;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [2:0]  tag;
    } alu_word;

    // One result FIFO slot: ROB tag plus the value to broadcast.
    typedef struct packed {
        logic [2:0] tag;
        cdb_data    data;
    } cdb_entry;

    // ARITH funct3
    localparam logic [2:0] ADD_SUB = 3'b000;
    localparam logic [2:0] SLL     = 3'b001;
    localparam logic [2:0] SLT     = 3'b010;
    localparam logic [2:0] SLTU    = 3'b011;
    localparam logic [2:0] XOR     = 3'b100;
    localparam logic [2:0] SR      = 3'b101;
    localparam logic [2:0] OR      = 3'b110;
    localparam logic [2:0] AND     = 3'b111;

    // BRANCH funct3
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/alu_cdb_issue_unit_alu_exec.sv
// Purely combinational ALU: alu_word in, 32-bit wrapping result out.
module alu_exec
    import tomasula_types::*;
(
    input  alu_word op_word,
    output cdb_data result
);

    logic [4:0]  shamt;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] sum;
    logic [31:0] diff;

    assign shamt = op_word.src2[4:0];
    assign eq    = (op_word.src1 == op_word.src2);
    assign lt_s  = ($signed(op_word.src1) < $signed(op_word.src2));
    assign lt_u  = (op_word.src1 < op_word.src2);
    assign sum   = op_word.src1 + op_word.src2;
    assign diff  = op_word.src1 - op_word.src2;

    // Select the result for the current operation class and funct3.
    always_comb begin
        result = '0;
        case (op_word.op)
            ARITH: begin
                case (op_word.funct3)
                    ADD_SUB: result = op_word.funct7 ? diff : sum;
                    SLL:     result = op_word.src1 << shamt;
                    SLT:     result = {31'b0, lt_s};
                    SLTU:    result = {31'b0, lt_u};
                    XOR:     result = op_word.src1 ^ op_word.src2;
                    SR:      result = op_word.funct7 ? 32'($signed(op_word.src1) >>> shamt)
                                                     : op_word.src1 >> shamt;
                    OR:      result = op_word.src1 | op_word.src2;
                    AND:     result = op_word.src1 & op_word.src2;
                    default: result = '0;
                endcase
            end
            BRANCH: begin
                case (op_word.funct3)
                    BEQ:     result = {31'b0, eq};
                    BNE:     result = {31'b0, ~eq};
                    BLT:     result = {31'b0, lt_s};
                    BGE:     result = {31'b0, ~lt_s};
                    BLTU:    result = {31'b0, lt_u};
                    BGEU:    result = {31'b0, ~lt_u};
                    default: result = '0;
                endcase
            end
            AUIPC:                   result = op_word.pc + op_word.src2;
            LUI:                     result = op_word.src2;
            JAL, JALR:               result = op_word.pc + 32'd4;
            LD, SB, SH, SW, CSR:     result = sum;
            default:                 result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cdb_issue_unit.sv
// ALU issue unit: one registered execute stage feeding an in-order result
// FIFO that is drained onto the common data bus under request/grant.
module alu_cdb_issue_unit
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  alu_word    alu_in,
    input  logic       alu_in_valid,
    output logic       alu_in_ready,
    output logic       cdb_req,
    input  logic       cdb_grant,
    output logic [2:0] cdb_tag,
    output cdb_data    cdb_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             s1_valid_q, s1_valid_d;
    alu_word          s1_q, s1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    cdb_entry         last_q, last_d;
    cdb_entry         mem [DEPTH];

    cdb_data          exec_result;
    cdb_entry         head;
    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             push;
    logic             pop;

    alu_exec u_alu_exec (
        .op_word (s1_q),
        .result  (exec_result)
    );

    // Every op in flight (s1 or FIFO) holds a FIFO credit, so s1 never stalls.
    assign occupancy    = {1'b0, count_q} + (CNT_W + 1)'(s1_valid_q);
    assign alu_in_ready = (occupancy < (CNT_W + 1)'(DEPTH));
    assign accept       = alu_in_valid && alu_in_ready;
    assign push         = s1_valid_q;
    assign cdb_req      = (count_q != '0);
    // A grant only counts while a request is being shown.
    assign pop          = cdb_req && cdb_grant;

    assign head    = mem[rd_ptr_q];
    // When empty, keep presenting whatever was last on the bus.
    assign cdb_tag = cdb_req ? head.tag  : last_q.tag;
    assign cdb_out = cdb_req ? head.data : last_q.data;

    // Next-state for stage 1, FIFO pointers/count and the held bus value.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_d     = last_q;

        if (cdb_req) begin
            last_d = head;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d = alu_in;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
        end
    end

    // FIFO storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr_q] <= '{tag: s1_q.tag, data: exec_result};
        end
    end

endmodule

// File: tb/tb_alu_cdb_issue_unit.sv
// Self-checking bench for alu_cdb_issue_unit: ALU vector table, hand-written
// handshake/flush/reset sequences and a randomized run against a queue model.
module tb_alu_cdb_issue_unit;
    import tomasula_types::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    alu_word    alu_in = '0;
    logic       alu_in_valid = 1'b0;
    logic       alu_in_ready;
    logic       cdb_req;
    logic       cdb_grant = 1'b0;
    logic [2:0] cdb_tag;
    cdb_data    cdb_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    cdb_entry q_m[$];
    bit       s1v_m = 1'b0;
    alu_word  s1_m  = '0;

    alu_cdb_issue_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alu_in       (alu_in),
        .alu_in_valid (alu_in_valid),
        .alu_in_ready (alu_in_ready),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_tag      (cdb_tag),
        .cdb_out      (cdb_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic alu_word mk(alu_op_t op, logic [2:0] f3, logic f7, logic [31:0] pc,
                                   logic [31:0] s1, logic [31:0] s2, logic [2:0] tag);
        alu_word w;
        w.op = op; w.funct3 = f3; w.funct7 = f7; w.pc = pc;
        w.src1 = s1; w.src2 = s2; w.tag = tag;
        return w;
    endfunction

    // Result computed from the ISA meaning of each op.
    function automatic logic [31:0] ref_result(alu_word w);
        logic [31:0] a, b, bias;
        int unsigned sh;
        logic s_lt, u_lt;
        a = w.src1; b = w.src2; bias = 32'h8000_0000;
        sh = int'(w.src2[4:0]);
        s_lt = (a ^ bias) < (b ^ bias);
        u_lt = a < b;
        case (w.op)
            ARITH: case (w.funct3)
                3'd0: return w.funct7 ? a + (~b + 32'd1) : a + b;
                3'd1: return a * (32'd1 << sh);
                3'd2: return {31'b0, s_lt};
                3'd3: return {31'b0, u_lt};
                3'd4: return a ^ b;
                3'd5: return w.funct7 ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0))
                                      : (a >> sh);
                3'd6: return a | b;
                default: return a & b;
            endcase
            BRANCH: case (w.funct3)
                3'd0: return {31'b0, a == b};
                3'd1: return {31'b0, a != b};
                3'd4: return {31'b0, s_lt};
                3'd5: return {31'b0, !s_lt};
                3'd6: return {31'b0, u_lt};
                3'd7: return {31'b0, !u_lt};
                default: return 32'h0;
            endcase
            AUIPC: return w.pc + b;
            LUI: return b;
            JAL, JALR: return w.pc + 32'd4;
            default: return a + b;
        endcase
    endfunction

    // Compare outputs with the model, advance one clock, update the model.
    task automatic tick();
        bit exp_ready, acc;
        exp_ready = (q_m.size() + int'(s1v_m)) < DEPTH;
        check("model_ready", alu_in_ready, exp_ready);
        check("model_req", cdb_req, q_m.size() != 0);
        if (q_m.size() != 0) begin
            check("model_tag", cdb_tag, q_m[0].tag);
            check("model_data", cdb_out, q_m[0].data);
        end
        acc = alu_in_valid && exp_ready;
        @(posedge clk);
        if (rst || flush) begin
            q_m.delete();
            s1v_m = 1'b0;
        end else begin
            if (q_m.size() != 0 && cdb_grant) void'(q_m.pop_front());
            if (s1v_m) begin
                n_cmp++;
                if (q_m.size() >= DEPTH) begin
                    n_fail++;
                    $display("FAIL credit_overflow: push into full FIFO, size %0d", q_m.size());
                end
                q_m.push_back('{tag: s1_m.tag, data: ref_result(s1_m)});
            end
            s1v_m = acc;
            s1_m  = alu_in;
        end
        #1;
    endtask

    typedef struct {
        alu_op_t     op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[25];

    initial begin
        int accepted;
        bit bad;
        vecs[0]  = '{ARITH,  3'd0, 1'b0, 32'h0,        32'd5,        32'd7,        3'd3, 32'd12};
        vecs[1]  = '{ARITH,  3'd5, 1'b1, 32'h0,        32'h8000_0000, 32'd4,       3'd1, 32'hF800_0000};
        vecs[2]  = '{BRANCH, 3'd6, 1'b0, 32'h0,        32'd1,        32'hFFFF_FFFF, 3'd2, 32'd1};
        vecs[3]  = '{ARITH,  3'd0, 1'b1, 32'h0,        32'd5,        32'd7,        3'd4, 32'hFFFF_FFFE};
        vecs[4]  = '{ARITH,  3'd1, 1'b0, 32'h0,        32'd1,        32'h23,       3'd5, 32'd8};
        vecs[5]  = '{ARITH,  3'd2, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd1,       3'd6, 32'd1};
        vecs[6]  = '{ARITH,  3'd3, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd1,       3'd7, 32'd0};
        vecs[7]  = '{ARITH,  3'd4, 1'b0, 32'h0,        32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 32'h0FF0_0FF0};
        vecs[8]  = '{ARITH,  3'd5, 1'b0, 32'h0,        32'h8000_0000, 32'd4,       3'd1, 32'h0800_0000};
        vecs[9]  = '{ARITH,  3'd6, 1'b0, 32'h0,        32'hF000_0000, 32'hF,       3'd2, 32'hF000_000F};
        vecs[10] = '{ARITH,  3'd7, 1'b0, 32'h0,        32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3, 32'hF000_F000};
        vecs[11] = '{BRANCH, 3'd0, 1'b0, 32'h0,        32'd7,        32'd7,        3'd4, 32'd1};
        vecs[12] = '{BRANCH, 3'd1, 1'b0, 32'h0,        32'd7,        32'd7,        3'd5, 32'd0};
        vecs[13] = '{BRANCH, 3'd4, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd0,       3'd6, 32'd1};
        vecs[14] = '{BRANCH, 3'd5, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd0,       3'd7, 32'd0};
        vecs[15] = '{BRANCH, 3'd7, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd0,       3'd0, 32'd1};
        vecs[16] = '{BRANCH, 3'd2, 1'b0, 32'h0,        32'd1,        32'd1,        3'd1, 32'd0};
        vecs[17] = '{AUIPC,  3'd0, 1'b0, 32'h2000,     32'd9,        32'hFFFF_F000, 3'd2, 32'h1000};
        vecs[18] = '{LUI,    3'd0, 1'b0, 32'h0,        32'd9,        32'h1234_5000, 3'd3, 32'h1234_5000};
        vecs[19] = '{JAL,    3'd0, 1'b0, 32'hFFFF_FFFC, 32'd9,       32'd9,        3'd4, 32'd0};
        vecs[20] = '{JALR,   3'd0, 1'b0, 32'h100,      32'd9,        32'd9,        3'd5, 32'h104};
        vecs[21] = '{LD,     3'd0, 1'b0, 32'h0,        32'h100,      32'hFFFF_FFFC, 3'd6, 32'hFC};
        vecs[22] = '{SW,     3'd0, 1'b0, 32'h0,        32'h10,       32'h20,       3'd7, 32'h30};
        vecs[23] = '{SB,     3'd0, 1'b0, 32'h0,        32'h8,        32'h8,        3'd0, 32'h10};
        vecs[24] = '{CSR,    3'd0, 1'b0, 32'h0,        32'd1,        32'd2,        3'd1, 32'd3};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_req", cdb_req, 0);
        check("reset_tag", cdb_tag, 0);
        check("reset_out", cdb_out, 0);
        check("reset_ready", alu_in_ready, 1);

        // ALU vector table, one op at a time with grant held high
        cdb_grant = 1'b1;
        foreach (vecs[i]) begin
            alu_in = mk(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].pc, vecs[i].s1, vecs[i].s2,
                        vecs[i].tag);
            alu_in_valid = 1'b1;
            tick();
            alu_in_valid = 1'b0;
            check($sformatf("vec%0d_req_early", i), cdb_req, 0);
            tick();
            check($sformatf("vec%0d_req", i), cdb_req, 1);
            check($sformatf("vec%0d_tag", i), cdb_tag, vecs[i].tag);
            check($sformatf("vec%0d_out", i), cdb_out, vecs[i].exp);
            tick();
            check($sformatf("vec%0d_single", i), cdb_req, 0);
        end

        // Backpressure: no grant, stream ops until credits run out
        cdb_grant = 1'b0;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            alu_in = mk(LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'h111 * (accepted + 1), 3'(accepted));
            alu_in_valid = (accepted < 6);
            check("bp_ready", alu_in_ready, accepted < DEPTH);
            if (alu_in_ready && alu_in_valid) accepted++;
            tick();
        end
        alu_in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), DEPTH);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_req", cdb_req, 1);
            check("bp_hold_tag", cdb_tag, 0);
            check("bp_hold_out", cdb_out, 32'h111);
            tick();
        end
        cdb_grant = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_req", cdb_req, 1);
            check("drain_tag", cdb_tag, k);
            tick();
        end
        check("drain_empty", cdb_req, 0);

        // Simultaneous push and pop with two entries buffered
        cdb_grant = 1'b0;
        for (int k = 0; k < 2; k++) begin
            alu_in = mk(ARITH, 3'd0, 1'b0, 32'h0, 32'd1000, 32'(k), 3'(k));
            alu_in_valid = 1'b1;
            tick();
        end
        alu_in_valid = 1'b0;
        tick();
        alu_in = mk(ARITH, 3'd0, 1'b0, 32'h0, 32'd1000, 32'd2, 3'd2);
        alu_in_valid = 1'b1;
        tick();
        cdb_grant = 1'b1;
        for (int k = 3; k < 13; k++) begin
            alu_in = mk(ARITH, 3'd0, 1'b0, 32'h0, 32'd1000, 32'(k), 3'(k));
            check("pp_req", cdb_req, 1);
            check("pp_ready", alu_in_ready, 1);
            check("pp_out", cdb_out, 32'd1000 + 32'(k - 3));
            tick();
        end
        alu_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("pp_empty", cdb_req, 0);

        // Flush with 3 buffered, 1 in s1 and a concurrent valid
        cdb_grant = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            alu_in = mk(LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'(k), 3'(k));
            alu_in_valid = 1'b1;
            tick();
        end
        check("fl_full_ready", alu_in_ready, 0);
        alu_in = mk(LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'd5, 3'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        alu_in_valid = 1'b0;
        check("fl_req", cdb_req, 0);
        check("fl_ready", alu_in_ready, 1);
        cdb_grant = 1'b1;
        alu_in = mk(LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'd6, 3'd6);
        alu_in_valid = 1'b1;
        tick();
        alu_in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bad = cdb_req && (cdb_tag >= 3'd1) && (cdb_tag <= 3'd5);
            check("fl_no_stale", bad, 0);
            tick();
        end

        // Reset mid-stream with a grant pending
        cdb_grant = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            alu_in = mk(ARITH, 3'd4, 1'b0, 32'h0, 32'hAA, 32'(k), 3'(k));
            alu_in_valid = 1'b1;
            tick();
        end
        cdb_grant = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_in_valid = 1'b0;
        check("rst_req", cdb_req, 0);
        check("rst_tag", cdb_tag, 0);
        check("rst_out", cdb_out, 0);
        check("rst_ready", alu_in_ready, 1);
        alu_in = mk(LUI, 3'd0, 1'b0, 32'h0, 32'h0, 32'hABCD, 3'd5);
        alu_in_valid = 1'b1;
        tick();
        alu_in_valid = 1'b0;
        check("rst_new_early", cdb_req, 0);
        tick();
        check("rst_new_req", cdb_req, 1);
        check("rst_new_tag", cdb_tag, 5);
        check("rst_new_out", cdb_out, 32'hABCD);
        tick();
        check("rst_new_single", cdb_req, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            alu_in = mk(alu_op_t'($urandom_range(0, 10)), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), $urandom, $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                        3'($urandom_range(0, 7)));
            alu_in_valid = ($urandom_range(0, 9) < 6);
            cdb_grant    = ($urandom_range(0, 1) == 1);
            flush        = ($urandom_range(0, 49) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        alu_in_valid = 1'b0;
        cdb_grant = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("final_empty", cdb_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
